wb_cfg_master: RTL and testbench

Wishbone classic single-cycle write initiator that programs the PWM/timer register file (ctrl, divisor, period, duty) over the same 16-bit bus the PWM top exposes as a slave.
It sits between a local controller (FSM or CPU shim) and the PWM block's i_wb_* inputs.
It takes either single write commands or a 4-register sequence load, and enforces an ack timeout.

---
 rtl/pwm_cfg_pkg.sv | 40 ++++
 rtl/wb_cfg_master_if.sv | 17 +
 rtl/wbm_timeout_cnt.sv | 29 ++
 rtl/wb_cfg_master.sv | 141 ++++++++++++++
 tb/tb_wb_cfg_master.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_cfg_pkg.sv
// Shared constants for the PWM/timer register file and the wb_cfg_master FSM:
// register map, ctrl bit positions, state encoding and sequence ordering.
package pwm_cfg_pkg;

   localparam logic [15:0] CTRL_ADR_C = 16'h0000;
   localparam logic [15:0] DIV_ADR_C  = 16'h0002;
   localparam logic [15:0] PER_ADR_C  = 16'h0004;
   localparam logic [15:0] DUTY_ADR_C = 16'h0006;

   localparam int CTRL_EXT_CLK_SEL = 0;
   localparam int CTRL_PWM_MODE    = 1;
   localparam int CTRL_CNT_EN      = 2;
   localparam int CTRL_CONT        = 3;
   localparam int CTRL_OUT_EN      = 4;
   localparam int CTRL_IRQ_CLR     = 5;
   localparam int CTRL_DUTY_SEL    = 6;
   localparam int CTRL_SOFT_RST    = 7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [1:0] SEQ_LAST = 2'd3;

   // Ctrl goes last so enables only take effect once timing is configured.
   function automatic logic [15:0] seq_adr(input logic [1:0] idx,
                                           input logic [15:0] ctrl_adr,
                                           input logic [15:0] div_adr,
                                           input logic [15:0] per_adr,
                                           input logic [15:0] duty_adr);
      case (idx)
         2'd0:    seq_adr = div_adr;
         2'd1:    seq_adr = per_adr;
         2'd2:    seq_adr = duty_adr;
         default: seq_adr = ctrl_adr;
      endcase
   endfunction

endpackage

// File: rtl/wb_cfg_master_if.sv
// Wishbone classic write-only bus between wb_cfg_master and the PWM slave.
interface wb_cfg_master_if #(
   parameter int ADR_W = 16,
   parameter int DAT_W = 16
);
   logic             o_wb_cyc;
   logic             o_wb_stb;
   logic             o_wb_we;
   logic [ADR_W-1:0] o_wb_adr;
   logic [DAT_W-1:0] o_wb_data;
   logic             i_wb_ack;

   modport master (output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data,
                   input  i_wb_ack);
   modport slave  (input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data,
                   output i_wb_ack);
endinterface

// File: rtl/wbm_timeout_cnt.sv
// Ack-wait counter: held at zero while cleared, counts enabled cycles and
// flags the cycle on which the count would reach the limit.
module wbm_timeout_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [CNT_W-1:0] i_limit,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_cnt;

   // Cycle counter, restarted whenever the master leaves REQ.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_expired = i_enable & (r_cnt == (i_limit - CNT_W'(1)));

endmodule

// File: rtl/wb_cfg_master.sv
// Wishbone classic write initiator for the PWM register file: single writes or
// a 4-register sequence load. Ack timeout abort is built only with WBM_TIMEOUT_EN.
module wb_cfg_master
   import pwm_cfg_pkg::*;
#(
   parameter int          ADR_W       = 16,
   parameter int          DAT_W       = 16,
   parameter int          TIMEOUT_CYC = 255,
   parameter logic [15:0] CTRL_ADR    = CTRL_ADR_C,
   parameter logic [15:0] DIV_ADR     = DIV_ADR_C,
   parameter logic [15:0] PER_ADR     = PER_ADR_C,
   parameter logic [15:0] DUTY_ADR    = DUTY_ADR_C
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [ADR_W-1:0] i_cmd_adr,
   input  logic [DAT_W-1:0] i_cmd_data,
   input  logic             i_seq_start,
   input  logic [DAT_W-1:0] i_seq_ctrl,
   input  logic [DAT_W-1:0] i_seq_div,
   input  logic [DAT_W-1:0] i_seq_period,
   input  logic [DAT_W-1:0] i_seq_duty,
   wb_cfg_master_if.master  wb,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   logic [1:0]       r_state;
   logic [1:0]       r_idx;
   logic             r_seq_mode;
   logic             r_cyc;
   logic [ADR_W-1:0] r_adr;
   logic [DAT_W-1:0] r_data;
   logic             r_done;
   logic             r_err;
   logic [DAT_W-1:0] r_seq_val [4];
   logic             w_expired;
   logic             w_in_req;

   assign w_in_req = (r_state == ST_REQ);

`ifdef WBM_TIMEOUT_EN
   wbm_timeout_cnt #(.CNT_W(16)) u_timeout (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (~w_in_req),
      .i_enable  (w_in_req & ~wb.i_wb_ack),
      .i_limit   (16'(TIMEOUT_CYC)),
      .o_expired (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   // Transfer FSM; sequence values are stored in bus order (div, per, duty, ctrl).
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state    <= ST_IDLE;
         r_idx      <= 2'd0;
         r_seq_mode <= 1'b0;
         r_cyc      <= 1'b0;
         r_adr      <= '0;
         r_data     <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         for (int i = 0; i < 4; i++) r_seq_val[i] <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_seq_start) begin
                  r_seq_val[0] <= i_seq_div;
                  r_seq_val[1] <= i_seq_period;
                  r_seq_val[2] <= i_seq_duty;
                  r_seq_val[3] <= i_seq_ctrl;
                  r_idx        <= 2'd0;
                  r_seq_mode   <= 1'b1;
                  r_adr        <= ADR_W'(seq_adr(2'd0, CTRL_ADR, DIV_ADR, PER_ADR, DUTY_ADR));
                  r_data       <= i_seq_div;
                  r_cyc        <= 1'b1;
                  r_state      <= ST_REQ;
               end else if (i_cmd_valid) begin
                  r_seq_mode <= 1'b0;
                  r_adr      <= i_cmd_adr;
                  r_data     <= i_cmd_data;
                  r_cyc      <= 1'b1;
                  r_state    <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (wb.i_wb_ack) begin
                  r_cyc <= 1'b0;
                  if (r_seq_mode && (r_idx != SEQ_LAST)) begin
                     r_idx   <= r_idx + 2'd1;
                     r_state <= ST_GAP;
                  end else begin
                     r_idx   <= 2'd0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end else if (w_expired) begin
                  r_cyc   <= 1'b0;
                  r_idx   <= 2'd0;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_GAP: begin
               r_adr   <= ADR_W'(seq_adr(r_idx, CTRL_ADR, DIV_ADR, PER_ADR, DUTY_ADR));
               r_data  <= r_seq_val[r_idx];
               r_cyc   <= 1'b1;
               r_state <= ST_REQ;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_cyc   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign wb.o_wb_cyc  = r_cyc;
   assign wb.o_wb_stb  = r_cyc;
   assign wb.o_wb_we   = r_cyc;
   assign wb.o_wb_adr  = r_adr;
   assign wb.o_wb_data = r_data;

   assign o_cmd_ready = i_rst & (r_state == ST_IDLE) & ~i_seq_start;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_wb_cfg_master.sv
// Directed self-checking bench for wb_cfg_master (TIMEOUT_CYC=8); the timeout
// scenario adapts to whether WBM_TIMEOUT_EN is defined.
module tb_wb_cfg_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_adr;
   logic [15:0] cmd_data;
   logic        seq_start;
   logic [15:0] seq_ctrl, seq_div, seq_period, seq_duty;
   logic        busy, done, err;
   logic [5:0]  flags;
   int          checks = 0;
   int          errors = 0;

   wb_cfg_master_if #(.ADR_W(16), .DAT_W(16)) wb_bus ();

   wb_cfg_master #(.ADR_W(16), .DAT_W(16), .TIMEOUT_CYC(8)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_adr    (cmd_adr),
      .i_cmd_data   (cmd_data),
      .i_seq_start  (seq_start),
      .i_seq_ctrl   (seq_ctrl),
      .i_seq_div    (seq_div),
      .i_seq_period (seq_period),
      .i_seq_duty   (seq_duty),
      .wb           (wb_bus.master),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   // {cyc, stb, we, busy, done, err}
   assign flags = {wb_bus.o_wb_cyc, wb_bus.o_wb_stb, wb_bus.o_wb_we, busy, done, err};

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; cmd_valid = 1'b1; cmd_adr = 16'h0004; cmd_data = 16'h1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({flags, cmd_ready} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs cyc%0d: got %b want 0000000", i, {flags, cmd_ready});
         end
         checks++;
         if ({wb_bus.o_wb_adr, wb_bus.o_wb_data} !== 32'h0) begin
            errors++; $display("FAIL reset_bus cyc%0d: got %h want 00000000", i, {wb_bus.o_wb_adr, wb_bus.o_wb_data});
         end
      end
      cmd_valid = 1'b0; rst = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_single();
      tick();
      cmd_valid = 1'b1; cmd_adr = 16'h0004; cmd_data = 16'h03E8;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL single_ready: got %b want 1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0; cmd_adr = 16'hFFFF; cmd_data = 16'hFFFF;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({flags, wb_bus.o_wb_adr, wb_bus.o_wb_data} !== {6'b111100, 16'h0004, 16'h03E8}) begin
            errors++; $display("FAIL single_req cyc%0d: got %b %h %h want 111100 0004 03e8",
                               i, flags, wb_bus.o_wb_adr, wb_bus.o_wb_data);
         end
         if (i == 1) wb_bus.i_wb_ack = 1'b1;
         tick();
      end
      wb_bus.i_wb_ack = 1'b0;
      checks++;
      if (flags !== 6'b000110) begin
         errors++; $display("FAIL single_done: got %b want 000110", flags);
      end
      tick();
      checks++;
      if (flags !== 6'b000000) begin
         errors++; $display("FAIL single_idle: got %b want 000000", flags);
      end
   endtask

   task automatic test_sequence();
      logic [15:0] exp_adr [4];
      logic [15:0] exp_dat [4];
      exp_adr = '{16'h0002, 16'h0004, 16'h0006, 16'h0000};
      exp_dat = '{16'h0004, 16'h0064, 16'h0032, 16'h0016};
      seq_ctrl = 16'h0016; seq_div = 16'h0004; seq_period = 16'h0064; seq_duty = 16'h0032;
      seq_start = 1'b1; wb_bus.i_wb_ack = 1'b1;
      tick();
      seq_start = 1'b0;
      seq_ctrl = 16'hDEAD; seq_div = 16'hDEAD; seq_period = 16'hDEAD; seq_duty = 16'hDEAD;
      for (int b = 0; b < 4; b++) begin
         checks++;
         if ({flags, wb_bus.o_wb_adr, wb_bus.o_wb_data} !== {6'b111100, exp_adr[b], exp_dat[b]}) begin
            errors++; $display("FAIL seq_beat%0d: got %b %h %h want 111100 %h %h",
                               b, flags, wb_bus.o_wb_adr, wb_bus.o_wb_data, exp_adr[b], exp_dat[b]);
         end
         tick();
         if (b < 3) begin
            checks++;
            if (flags !== 6'b000100) begin
               errors++; $display("FAIL seq_gap%0d: got %b want 000100", b, flags);
            end
            tick();
         end
      end
      checks++;
      if (flags !== 6'b000110) begin
         errors++; $display("FAIL seq_done: got %b want 000110", flags);
      end
      tick();
      wb_bus.i_wb_ack = 1'b0;
      checks++;
      if (flags !== 6'b000000) begin
         errors++; $display("FAIL seq_idle: got %b want 000000", flags);
      end
   endtask

   task automatic test_timeout();
      cmd_valid = 1'b1; cmd_adr = 16'h0000; cmd_data = 16'h00AA;
      tick();
      cmd_valid = 1'b0;
`ifdef WBM_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (flags !== 6'b111100) begin
            errors++; $display("FAIL timeout_req cyc%0d: got %b want 111100", i, flags);
         end
         tick();
      end
      checks++;
      if (flags !== 6'b000111) begin
         errors++; $display("FAIL timeout_abort: got %b want 000111", flags);
      end
      tick();
      checks++;
      if (flags !== 6'b000000) begin
         errors++; $display("FAIL timeout_idle: got %b want 000000", flags);
      end
      // Ack arriving on the limit edge is a success.
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      checks++;
      if (flags !== 6'b111100) begin
         errors++; $display("FAIL limit_req: got %b want 111100", flags);
      end
      wb_bus.i_wb_ack = 1'b1;
      tick();
      wb_bus.i_wb_ack = 1'b0;
      checks++;
      if (flags !== 6'b000110) begin
         errors++; $display("FAIL limit_ack_success: got %b want 000110", flags);
      end
      tick();
`else
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (flags !== 6'b111100) begin
            errors++; $display("FAIL noto_hold cyc%0d: got %b want 111100", i, flags);
         end
         tick();
      end
      wb_bus.i_wb_ack = 1'b1;
      tick();
      wb_bus.i_wb_ack = 1'b0;
      checks++;
      if (flags !== 6'b000110) begin
         errors++; $display("FAIL noto_done: got %b want 000110", flags);
      end
      tick();
`endif
   endtask

   task automatic test_priority();
      seq_ctrl = 16'h0016; seq_div = 16'h0004; seq_period = 16'h0064; seq_duty = 16'h0032;
      cmd_valid = 1'b1; cmd_adr = 16'h0006; cmd_data = 16'h1234;
      seq_start = 1'b1; wb_bus.i_wb_ack = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++; $display("FAIL prio_ready: got %b want 0", cmd_ready);
      end
      tick();
      seq_start = 1'b0;
      checks++;
      if (wb_bus.o_wb_adr !== 16'h0002) begin
         errors++; $display("FAIL prio_seq_first: got %h want 0002", wb_bus.o_wb_adr);
      end
      for (int i = 1; i < 8; i++) begin
         checks++;
         if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL prio_busy_ready cyc%0d: got %b want 0", i, cmd_ready);
         end
         tick();
      end
      checks++;
      if ({flags, cmd_ready} !== 7'b0001100) begin
         errors++; $display("FAIL prio_seq_done: got %b want 0001100", {flags, cmd_ready});
      end
      tick();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL prio_idle_ready: got %b want 1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({flags, wb_bus.o_wb_adr, wb_bus.o_wb_data} !== {6'b111100, 16'h0006, 16'h1234}) begin
         errors++; $display("FAIL prio_cmd_req: got %b %h %h want 111100 0006 1234",
                            flags, wb_bus.o_wb_adr, wb_bus.o_wb_data);
      end
      tick();
      checks++;
      if (flags !== 6'b000110) begin
         errors++; $display("FAIL prio_cmd_done: got %b want 000110", flags);
      end
      tick();
      wb_bus.i_wb_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      seq_ctrl = 16'h0016; seq_div = 16'h0009; seq_period = 16'h0064; seq_duty = 16'h0032;
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      wb_bus.i_wb_ack = 1'b1;
      tick();
      wb_bus.i_wb_ack = 1'b0;
      tick();
      checks++;
      if ({flags, wb_bus.o_wb_adr} !== {6'b111100, 16'h0004}) begin
         errors++; $display("FAIL rmid_beat2: got %b %h want 111100 0004", flags, wb_bus.o_wb_adr);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({flags, wb_bus.o_wb_adr, wb_bus.o_wb_data} !== {6'b000000, 32'h0}) begin
         errors++; $display("FAIL rmid_drop: got %b %h %h want 000000 0000 0000",
                            flags, wb_bus.o_wb_adr, wb_bus.o_wb_data);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (flags !== 6'b000000) begin
         errors++; $display("FAIL rmid_no_done: got %b want 000000", flags);
      end
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      checks++;
      if ({flags, wb_bus.o_wb_adr, wb_bus.o_wb_data} !== {6'b111100, 16'h0002, 16'h0009}) begin
         errors++; $display("FAIL rmid_restart: got %b %h %h want 111100 0002 0009",
                            flags, wb_bus.o_wb_adr, wb_bus.o_wb_data);
      end
      wb_bus.i_wb_ack = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      checks++;
      if (flags !== 6'b000110) begin
         errors++; $display("FAIL rmid_seq_done: got %b want 000110", flags);
      end
      tick();
      wb_bus.i_wb_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_adr = 16'h0; cmd_data = 16'h0;
      seq_start = 1'b0; seq_ctrl = 16'h0; seq_div = 16'h0; seq_period = 16'h0; seq_duty = 16'h0;
      wb_bus.i_wb_ack = 1'b0;
      test_reset();
      test_single();
      test_sequence();
      test_timeout();
      test_priority();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
